modbus_frame_tx: RTL and testbench

MODBUS_FRAME_TX -- requirements
Module: modbus_frame_tx

---
 rtl/modbus_frame_tx_if.sv | 24 ++
 rtl/modbus_frame_tx.sv | 164 ++++++++++++++++
 tb/tb_modbus_frame_tx.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_frame_tx_if.sv
// modbus_frame_tx_if
//   Byte stream handshake between the Modbus frame builder and a UART
//   transmitter.
//   tx_data  : byte presented to the UART (valid only while tx_valid=1)
//   tx_valid : tx_data valid, held until accepted
//   tx_ready : UART accepts tx_data on a clock edge where tx_valid=1
//   master modport: frame builder side; slave modport: UART side.
interface modbus_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/modbus_frame_tx.sv
// modbus_frame_tx
//   Serialises a BYTES-long payload onto a valid/ready byte stream and
//   follows it with the Modbus CRC-16 (poly 0xA001 reflected, init 0xFFFF),
//   low byte first. The CRC is computed bit-serially, one byte per 9 cycles,
//   interleaved with the byte transmission.
//
//   Parameters:
//     BYTES      : payload bytes per frame (1..255), CRC excluded
//     GAP_CYCLES : post-frame silence length in clk_in cycles
//   Ports:
//     clk_in        : clock, rising edge
//     rst_in        : synchronous active-high reset
//     data_in       : payload, byte k at [8k+7:8k], byte 0 sent first
//     tx_start      : frame request, sampled only when idle
//     tx_if         : tx_data / tx_valid / tx_ready byte handshake (master)
//     busy          : high from the cycle after start acceptance until idle
//     tx_frame_done : one-cycle pulse at frame completion
//     crc_out       : CRC of the last completed frame, low byte in [7:0]
//
//   Build option: define MODBUS_TX_GAP_EN to insert GAP_CYCLES of silence
//   (busy held, tx_valid low) after the CRC high byte is accepted.
module modbus_frame_tx #(
    parameter int unsigned BYTES      = 'd6,
    parameter int unsigned GAP_CYCLES = 'd1750
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [8*BYTES-1:0]   data_in,
    input  logic                 tx_start,
    modbus_frame_tx_if.master    tx_if,
    output logic                 busy,
    output logic                 tx_frame_done,
    output logic [15:0]          crc_out
);

    localparam logic [7:0] LAST_BYTE = 8'(BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XOR,
        ST_SHIFT,
        ST_SEND,
        ST_SEND_LO,
        ST_SEND_HI,
`ifdef MODBUS_TX_GAP_EN
        ST_GAP,
`endif
        ST_DONE
    } state_t;

    state_t               state;
    logic [8*BYTES-1:0]   shift_buf;
    logic [15:0]          crc;
    logic [7:0]           byte_cnt;
    logic [2:0]           bit_cnt;

`ifdef MODBUS_TX_GAP_EN
    localparam int unsigned  GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    function automatic logic [15:0] crc_step(input logic [15:0] c);
        return c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            shift_buf      <= '0;
            crc            <= '0;
            byte_cnt       <= '0;
            bit_cnt        <= '0;
            busy           <= 1'b0;
            tx_frame_done  <= 1'b0;
            crc_out        <= '0;
            tx_if.tx_valid <= 1'b0;
            tx_if.tx_data  <= '0;
`ifdef MODBUS_TX_GAP_EN
            gap_cnt        <= '0;
`endif
        end else begin
            tx_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        shift_buf <= data_in;
                        crc       <= 16'hFFFF;
                        byte_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= ST_XOR;
                    end
                end
                ST_XOR: begin
                    crc[7:0] <= crc[7:0] ^ shift_buf[7:0];
                    bit_cnt  <= '0;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    crc     <= crc_step(crc);
                    bit_cnt <= bit_cnt + 3'd1;
                    // Load the byte into the output register on the last shift
                    // so tx_valid/tx_data are registered when SEND begins.
                    if (bit_cnt == 3'd7) begin
                        state          <= ST_SEND;
                        tx_if.tx_valid <= 1'b1;
                        tx_if.tx_data  <= shift_buf[7:0];
                    end
                end
                ST_SEND: begin
                    if (tx_if.tx_ready) begin
                        shift_buf <= shift_buf >> 8;
                        byte_cnt  <= byte_cnt + 8'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            // crc is final here: the last SHIFT has completed.
                            state         <= ST_SEND_LO;
                            tx_if.tx_data <= crc[7:0];
                        end else begin
                            state          <= ST_XOR;
                            tx_if.tx_valid <= 1'b0;
                        end
                    end
                end
                ST_SEND_LO: begin
                    if (tx_if.tx_ready) begin
                        tx_if.tx_data <= crc[15:8];
                        state         <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    if (tx_if.tx_ready) begin
                        crc_out        <= crc;
                        tx_if.tx_valid <= 1'b0;
`ifdef MODBUS_TX_GAP_EN
                        gap_cnt        <= '0;
                        state          <= ST_GAP;
`else
                        tx_frame_done  <= 1'b1;
                        state          <= ST_DONE;
`endif
                    end
                end
`ifdef MODBUS_TX_GAP_EN
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        tx_frame_done <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// tb_modbus_frame_tx
//   Self-checking bench for modbus_frame_tx. A reference model computes the
//   expected byte stream (payload then CRC-16 low/high) from the payload
//   with a plain bitwise CRC loop; a negedge monitor records every accepted
//   byte, done pulses and output stability while stalled.
module tb_modbus_frame_tx;
    localparam int BYTES = 6;
    localparam int GAP   = 16;
`ifdef MODBUS_TX_GAP_EN
    localparam int GAP_EXP = GAP;
`else
    localparam int GAP_EXP = 0;
`endif

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 tx_start = 1'b0;
    logic [8*BYTES-1:0]   data_in = '0;
    logic                 busy;
    logic                 tx_frame_done;
    logic [15:0]          crc_out;

    modbus_frame_tx_if bus ();

    modbus_frame_tx #(.BYTES(BYTES), .GAP_CYCLES(GAP)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .data_in       (data_in),
        .tx_start      (tx_start),
        .tx_if         (bus),
        .busy          (busy),
        .tx_frame_done (tx_frame_done),
        .crc_out       (crc_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Monitor state
    logic [7:0] got[$];
    int         done_cnt = 0;
    int         stall_viol = 0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         done_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       busy_at_start;

    // Reference model output
    logic [7:0]  exp_q[$];
    logic [15:0] exp_crc;

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(bus.tx_valid && bus.tx_data == prev_data))
                stall_viol++;
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                got.push_back(bus.tx_data);
                last_acc_cyc = cyc;
            end
            if (tx_frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Modbus CRC-16: init FFFF, per byte xor into low byte then 8 reflected
    // shifts with polynomial A001; appended low byte first.
    task automatic build_expected(input logic [8*BYTES-1:0] d);
        logic [15:0] c;
        logic [7:0]  b;
        exp_q.delete();
        c = 16'hFFFF;
        for (int k = 0; k < BYTES; k++) begin
            b = d[8*k +: 8];
            exp_q.push_back(b);
            c = c ^ {8'h00, b};
            for (int i = 0; i < 8; i++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_crc = c;
    endtask

    function automatic int first_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [8*BYTES-1:0] rand_payload();
        logic [8*BYTES-1:0] d;
        for (int k = 0; k < BYTES; k++) d[8*k +: 8] = 8'($urandom_range(255));
        return d;
    endfunction

    // Runs one frame; ready_pct<100 randomises tx_ready each cycle,
    // disturb_at>0 re-pulses tx_start and corrupts data_in mid-frame.
    task automatic run_frame(input logic [8*BYTES-1:0] d, input int ready_pct,
                             input int disturb_at, output int n_done);
        int n;
        got.delete();
        done_cnt = 0;
        data_in  = d;
        tx_start = 1'b1;
        bus.tx_ready = 1'b1;
        @(posedge clk_in); #1;
        tx_start = 1'b0;
        busy_at_start = busy;
        n = 0;
        n_done = -1;
        while (n < 4000 && n_done < 0) begin
            if (ready_pct < 100) bus.tx_ready = ($urandom_range(99) < ready_pct);
            if (disturb_at != 0 && n == disturb_at) begin
                tx_start = 1'b1;
                data_in  = ~d;
            end else begin
                tx_start = 1'b0;
            end
            @(posedge clk_in); #1;
            n++;
            if (tx_frame_done) n_done = n;
        end
        tx_start = 1'b0;
        bus.tx_ready = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tx_start = 1'b1;
        bus.tx_ready = 1'b1;
        data_in = rand_payload();
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b exp 0", bus.tx_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++;
        if (tx_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", tx_frame_done); end
        checks++;
        if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %0h exp 00", bus.tx_data); end
        checks++;
        if (crc_out !== 16'h0000) begin errors++; $display("FAIL reset_crc_out got %0h exp 0000", crc_out); end
        tx_start = 1'b0;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %0b exp 0", busy); end
    endtask

    task automatic test_known_frame();
        logic [7:0] lit [8];
        int n_done, idx;
        lit = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        run_frame(48'h0A_00_00_00_03_01, 100, 0, n_done);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(lit[i]);
        idx = first_diff();
        checks++;
        if (idx >= 0) begin errors++; $display("FAIL known_seq idx %0d got %0d bytes exp %0d bytes", idx, got.size(), exp_q.size()); end
        checks++;
        if (crc_out !== 16'hCDC5) begin errors++; $display("FAIL known_crc_out got %0h exp cdc5", crc_out); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL known_done_pulses got %0d exp 1", done_cnt); end
        checks++;
        if (busy_at_start !== 1'b1) begin errors++; $display("FAIL known_busy_rise got %0b exp 1", busy_at_start); end
        checks++;
        if (n_done !== 62 + GAP_EXP) begin errors++; $display("FAIL known_latency got %0d exp %0d", n_done, 62 + GAP_EXP); end
        checks++;
        if (done_cyc - last_acc_cyc !== 1 + GAP_EXP) begin
            errors++; $display("FAIL gap_to_done got %0d exp %0d", done_cyc - last_acc_cyc, 1 + GAP_EXP);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL known_busy_end got %0b exp 0", busy); end
    endtask

    task automatic test_random_frames();
        logic [8*BYTES-1:0] d;
        int n_done, idx, pct;
        for (int t = 0; t < 6; t++) begin
            d = rand_payload();
            pct = (t == 0) ? 100 : int'($urandom_range(95, 30));
            run_frame(d, pct, 0, n_done);
            build_expected(d);
            idx = first_diff();
            checks++;
            if (idx >= 0) begin errors++; $display("FAIL rand_seq t%0d idx %0d got %0d bytes exp %0d", t, idx, got.size(), exp_q.size()); end
            checks++;
            if (crc_out !== exp_crc) begin errors++; $display("FAIL rand_crc_out t%0d got %0h exp %0h", t, crc_out, exp_crc); end
            checks++;
            if (done_cnt !== 1 || n_done < 0) begin errors++; $display("FAIL rand_done t%0d got %0d pulses exp 1", t, done_cnt); end
            checks++;
            if (stall_viol !== 0) begin errors++; $display("FAIL rand_stall_hold t%0d got %0d violations exp 0", t, stall_viol); end
        end
    endtask

    task automatic test_backpressure();
        logic [8*BYTES-1:0] d;
        int n, idx;
        d = 48'h0A_00_00_00_03_01;
        got.delete();
        done_cnt = 0;
        data_in = d;
        bus.tx_ready = 1'b1;
        tx_start = 1'b1;
        @(posedge clk_in); #1;
        tx_start = 1'b0;
        n = 0;
        while (got.size() < 1 && n < 200) begin @(posedge clk_in); #1; n++; end
        bus.tx_ready = 1'b0;
        n = 0;
        while (bus.tx_valid !== 1'b1 && n < 200) begin @(posedge clk_in); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h03) begin
                errors++; $display("FAIL bp_hold c%0d got valid %0b data %0h exp valid 1 data 03", i, bus.tx_valid, bus.tx_data);
            end
            @(posedge clk_in); #1;
        end
        bus.tx_ready = 1'b1;
        n = 0;
        while (tx_frame_done !== 1'b1 && n < 400) begin @(posedge clk_in); #1; n++; end
        @(posedge clk_in); #1;
        build_expected(d);
        idx = first_diff();
        checks++;
        if (idx >= 0) begin errors++; $display("FAIL bp_seq idx %0d got %0d bytes exp %0d", idx, got.size(), exp_q.size()); end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_hold got %0d violations exp 0", stall_viol); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_restart_ignored();
        logic [8*BYTES-1:0] d;
        int n_done, idx;
        d = 48'h0A_00_00_00_03_01;
        run_frame(d, 100, 25, n_done);
        build_expected(d);
        idx = first_diff();
        checks++;
        if (idx >= 0) begin errors++; $display("FAIL restart_seq idx %0d got %0d bytes exp %0d", idx, got.size(), exp_q.size()); end
        checks++;
        if (crc_out !== 16'hCDC5) begin errors++; $display("FAIL restart_crc_out got %0h exp cdc5", crc_out); end
        checks++;
        if (n_done !== 62 + GAP_EXP || done_cnt !== 1) begin
            errors++; $display("FAIL restart_timing got %0d cycles %0d pulses exp %0d cycles 1 pulse", n_done, done_cnt, 62 + GAP_EXP);
        end
    endtask

    task automatic test_reset_mid();
        logic [8*BYTES-1:0] d;
        int n, n_done, idx;
        d = rand_payload();
        got.delete();
        done_cnt = 0;
        data_in = d;
        bus.tx_ready = 1'b1;
        tx_start = 1'b1;
        @(posedge clk_in); #1;
        tx_start = 1'b0;
        n = 0;
        while (got.size() < 2 && n < 200) begin @(posedge clk_in); #1; n++; end
        // now in XOR of byte index 2; advance two cycles into its SHIFT
        repeat (2) begin @(posedge clk_in); #1; end
        rst_in = 1'b1;
        tx_start = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        tx_start = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got valid %0b busy %0b exp 0 0", bus.tx_valid, busy);
        end
        checks++;
        if (crc_out !== 16'h0000) begin errors++; $display("FAIL midrst_crc_out got %0h exp 0000", crc_out); end
        repeat (100) @(posedge clk_in);
        #1;
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_aborted got %0d pulses busy %0b exp 0 0", done_cnt, busy);
        end
        d = rand_payload();
        run_frame(d, 100, 0, n_done);
        build_expected(d);
        idx = first_diff();
        checks++;
        if (idx >= 0 || crc_out !== exp_crc || done_cnt !== 1) begin
            errors++; $display("FAIL midrst_next_frame idx %0d crc got %0h exp %0h pulses %0d", idx, crc_out, exp_crc, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [8*BYTES-1:0] d1, d2;
        logic [7:0] e1[$];
        int n, idx;
        d1 = rand_payload();
        d2 = rand_payload();
        got.delete();
        done_cnt = 0;
        bus.tx_ready = 1'b1;
        data_in = d1;
        tx_start = 1'b1;
        @(posedge clk_in); #1;
        data_in = d2;
        n = 0;
        while (tx_frame_done !== 1'b1 && n < 400) begin @(posedge clk_in); #1; n++; end
        checks++;
        if (tx_frame_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got 0 exp 1 within bound"); end
        @(posedge clk_in); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy got %0b exp 0", busy); end
        @(posedge clk_in); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart busy got %0b exp 1", busy); end
        tx_start = 1'b0;
        n = 0;
        while (tx_frame_done !== 1'b1 && n < 400) begin @(posedge clk_in); #1; n++; end
        @(posedge clk_in); #1;
        build_expected(d1);
        e1 = exp_q;
        build_expected(d2);
        exp_q = {e1, exp_q};
        idx = first_diff();
        checks++;
        if (idx >= 0) begin errors++; $display("FAIL b2b_seq idx %0d got %0d bytes exp %0d", idx, got.size(), exp_q.size()); end
        checks++;
        if (done_cnt !== 2 || crc_out !== exp_crc) begin
            errors++; $display("FAIL b2b_done pulses %0d crc got %0h exp 2 pulses crc %0h", done_cnt, crc_out, exp_crc);
        end
    endtask

    initial begin
        bus.tx_ready = 1'b1;
        test_reset();
        test_known_frame();
        test_random_frames();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
